// File: rtl/ch0re_hazard_fwd_unit.sv
// Forwarding and hazard unit for the ch0re RV64I pipeline: shadow scoreboard of
// in-flight writers, operand bypass into ID/EX, load-use stalls, redirect flushes.
module ch0re_hazard_fwd_unit #(
    parameter  int XLEN           = 64,
    parameter  int NUM_FWD_STAGES = 3,
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int LOAD_LAT       = 2,
    parameter  int CNT_WIDTH      = 32,
    localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_hold,
    input  logic                           i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]      i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]      i_id_rs2,
    input  logic                           i_id_rs1_used,
    input  logic                           i_id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]      i_id_rd,
    input  logic                           i_id_wen,
    input  logic                           i_id_is_load,
    input  logic [XLEN-1:0]                i_rf_rdata1,
    input  logic [XLEN-1:0]                i_rf_rdata2,
    input  logic [NUM_FWD_STAGES*XLEN-1:0] i_stage_data,
    input  logic                           i_redirect,
    output logic [XLEN-1:0]                o_rs1_data,
    output logic [XLEN-1:0]                o_rs2_data,
    output logic [SEL_W-1:0]               o_fwd1_sel,
    output logic [SEL_W-1:0]               o_fwd2_sel,
    output logic                           o_stall,
    output logic                           o_flush_if,
    output logic                           o_flush_id,
    output logic [CNT_WIDTH-1:0]           o_stall_cycles,
    output logic [CNT_WIDTH-1:0]           o_flush_count
);

    logic [NUM_FWD_STAGES-1:0] valid_q;
    logic [NUM_FWD_STAGES-1:0] wen_q;
    logic [NUM_FWD_STAGES-1:0] load_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q [NUM_FWD_STAGES];

    logic [REG_ADDR_WIDTH-1:0] src_addr [2];
    logic                      src_used [2];
    logic [XLEN-1:0]           rf_data  [2];

    logic            hit      [2];
    logic            rdy      [2];
    logic [SEL_W-1:0] sel     [2];
    logic [XLEN-1:0] fwd_data [2];

    logic stall;
    logic flush;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    assign src_addr[0] = i_id_rs1;
    assign src_addr[1] = i_id_rs2;
    assign src_used[0] = i_id_rs1_used;
    assign src_used[1] = i_id_rs2_used;
    assign rf_data[0]  = i_rf_rdata1;
    assign rf_data[1]  = i_rf_rdata2;

    // Scan oldest to youngest so the youngest matching writer is the one that sticks.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            // NOTE: every combinational output gets a default first so no latch is inferred.
            hit[s]      = 1'b0;
            rdy[s]      = 1'b0;
            sel[s]      = '0;
            fwd_data[s] = rf_data[s];
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                if (src_used[s] && (src_addr[s] != '0) && valid_q[k] && wen_q[k]
                    && (rd_q[k] == src_addr[s])) begin
                    hit[s]      = 1'b1;
                    rdy[s]      = !load_q[k] || (k >= LOAD_LAT);
                    sel[s]      = SEL_W'(k + 1);
                    fwd_data[s] = i_stage_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    assign o_fwd1_sel = (hit[0] && rdy[0]) ? sel[0] : '0;
    assign o_fwd2_sel = (hit[1] && rdy[1]) ? sel[1] : '0;
    assign o_rs1_data = (hit[0] && rdy[0]) ? fwd_data[0] : i_rf_rdata1;
    assign o_rs2_data = (hit[1] && rdy[1]) ? fwd_data[1] : i_rf_rdata2;

    // A redirect squashes the dependent instruction, so it never also stalls.
    assign stall = !rst && i_id_valid && !i_redirect
                   && ((hit[0] && !rdy[0]) || (hit[1] && !rdy[1]));
    assign flush = !rst && i_redirect && !i_hold;

    assign o_stall    = stall;
    assign o_flush_if = flush;
    assign o_flush_id = flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            wen_q   <= '0;
            load_q  <= '0;
            // NOTE: the scoreboard is a handful of flops, not a RAM, so clearing it on reset is cheap and required.
            for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                rd_q[k] <= '0;
            end
        end else if (!i_hold) begin
            // NOTE: non-blocking assignments let every entry shift from its old neighbour in the same edge.
            for (int k = NUM_FWD_STAGES - 1; k > 0; k--) begin
                valid_q[k] <= valid_q[k-1];
                wen_q[k]   <= wen_q[k-1];
                load_q[k]  <= load_q[k-1];
                rd_q[k]    <= rd_q[k-1];
            end
            valid_q[0] <= i_id_valid && !i_redirect && !stall;
            wen_q[0]   <= i_id_wen;
            load_q[0]  <= i_id_is_load;
            rd_q[0]    <= i_id_rd;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!i_hold) begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cycles = stall_cnt_q;
    assign o_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_ch0re_hazard_fwd_unit.sv
// Self-checking bench for ch0re_hazard_fwd_unit: cycle-by-cycle vector table through
// a scoreboard queue, plus hand sequences for async reset and counter saturation.
module tb_ch0re_hazard_fwd_unit;

    localparam logic [63:0] RF1 = 64'hF1F1;
    localparam logic [63:0] RF2 = 64'hF2F2;
    localparam logic [63:0] SD0 = 64'hC000;
    localparam logic [63:0] SD1 = 64'hC111;
    localparam logic [63:0] SD2 = 64'hC222;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold, id_valid, u1, u2, wen, ld, redirect;
    logic [4:0]   rs1, rs2, rd;
    logic [63:0]  rf1, rf2;
    logic [191:0] stage_data;

    logic [63:0] a_rs1, a_rs2;
    logic [1:0]  a_sel1, a_sel2;
    logic        a_stall, a_fif, a_fid;
    logic [31:0] a_scnt, a_fcnt;

    logic [63:0] b_rs1, b_rs2;
    logic [1:0]  b_sel1, b_sel2;
    logic        b_stall, b_fif, b_fid;
    logic [3:0]  b_scnt, b_fcnt;

    always #5 clk = ~clk;

    ch0re_hazard_fwd_unit dut (
        .clk(clk), .rst(rst), .i_hold(hold), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(u1), .i_id_rs2_used(u2),
        .i_id_rd(rd), .i_id_wen(wen), .i_id_is_load(ld),
        .i_rf_rdata1(rf1), .i_rf_rdata2(rf2), .i_stage_data(stage_data),
        .i_redirect(redirect),
        .o_rs1_data(a_rs1), .o_rs2_data(a_rs2), .o_fwd1_sel(a_sel1), .o_fwd2_sel(a_sel2),
        .o_stall(a_stall), .o_flush_if(a_fif), .o_flush_id(a_fid),
        .o_stall_cycles(a_scnt), .o_flush_count(a_fcnt)
    );

    ch0re_hazard_fwd_unit #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .i_hold(hold), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(u1), .i_id_rs2_used(u2),
        .i_id_rd(rd), .i_id_wen(wen), .i_id_is_load(ld),
        .i_rf_rdata1(rf1), .i_rf_rdata2(rf2), .i_stage_data(stage_data),
        .i_redirect(redirect),
        .o_rs1_data(b_rs1), .o_rs2_data(b_rs2), .o_fwd1_sel(b_sel1), .o_fwd2_sel(b_sel2),
        .o_stall(b_stall), .o_flush_if(b_fif), .o_flush_id(b_fid),
        .o_stall_cycles(b_scnt), .o_flush_count(b_fcnt)
    );

    typedef struct {
        logic        hold, valid, redirect;
        logic [4:0]  rs1;  logic u1;
        logic [4:0]  rs2;  logic u2;
        logic [4:0]  rd;   logic wen, ld;
        logic [63:0] sd0, sd1, sd2;
        logic        chk_fwd;
        logic [1:0]  sel1, sel2;
        logic [63:0] d1, d2;
        logic        stall, flush;
    } vec_t;

    typedef struct {
        int          idx;
        logic        chk_fwd;
        logic [1:0]  sel1, sel2;
        logic [63:0] d1, d2;
        logic        stall, flush;
        int          scnt, fcnt;
    } exp_t;

    vec_t tbl [24];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic h, input logic val, input logic redir,
                               input logic [4:0] r1, input logic us1,
                               input logic [4:0] r2, input logic us2,
                               input logic [4:0] d, input logic we, input logic isld,
                               input logic chk, input logic [1:0] s1, input logic [1:0] s2,
                               input logic [63:0] e1, input logic [63:0] e2,
                               input logic st, input logic fl);
        vec_t t;
        t.hold = h; t.valid = val; t.redirect = redir;
        t.rs1 = r1; t.u1 = us1; t.rs2 = r2; t.u2 = us2;
        t.rd = d; t.wen = we; t.ld = isld;
        t.sd0 = SD0; t.sd1 = SD1; t.sd2 = SD2;
        t.chk_fwd = chk; t.sel1 = s1; t.sel2 = s2; t.d1 = e1; t.d2 = e2;
        t.stall = st; t.flush = fl;
        return t;
    endfunction

    task automatic drive_id(input logic val, input logic [4:0] r1, input logic us1,
                            input logic [4:0] r2, input logic us2,
                            input logic [4:0] d, input logic we, input logic isld);
        id_valid = val; rs1 = r1; u1 = us1; rs2 = r2; u2 = us2;
        rd = d; wen = we; ld = isld; hold = 1'b0; redirect = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " sel1"},  64'(a_sel1), 64'd0);
        check({tag, " sel2"},  64'(a_sel2), 64'd0);
        check({tag, " rs1"},   a_rs1, rf1);
        check({tag, " rs2"},   a_rs2, rf2);
        check({tag, " stall"}, 64'(a_stall), 64'd0);
        check({tag, " flush"}, 64'({a_fif, a_fid}), 64'd0);
        check({tag, " scnt"},  64'(a_scnt), 64'd0);
        check({tag, " fcnt"},  64'(a_fcnt), 64'd0);
        check({tag, " sat scnt"}, 64'(b_scnt), 64'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        rf1 = RF1; rf2 = RF2;
        stage_data = {SD2, SD1, SD0};
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        //            h  v  r  rs1 u   rs2 u   rd  w  ld chk s1 s2 d1          d2    st fl
        tbl[0]  = v(0, 1, 0,  1, 1,  2, 1,  5, 1, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[1]  = v(0, 1, 0,  5, 1,  5, 1,  6, 1, 0, 1, 1, 1, 64'h1234,   64'h1234,  0, 0);
        tbl[1].sd0 = 64'h1234;
        tbl[2]  = v(0, 1, 0,  5, 1,  0, 0,  7, 1, 1, 1, 2, 0, SD1,        RF2,       0, 0);
        tbl[3]  = v(0, 1, 0,  7, 1,  0, 1,  8, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[4]  = v(0, 1, 0,  7, 1,  0, 1,  8, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[5]  = v(0, 1, 0,  7, 1,  0, 1,  8, 1, 0, 1, 3, 0, SD2,        RF2,       0, 0);
        tbl[6]  = v(0, 1, 0,  0, 0,  0, 0,  9, 1, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[7]  = v(0, 1, 0,  0, 0,  0, 0,  3, 0, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[8]  = v(0, 1, 0,  0, 0,  0, 0,  9, 1, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[9]  = v(0, 1, 0,  9, 1,  9, 1,  4, 0, 0, 1, 1, 1, 64'hBB,     64'hBB,    0, 0);
        tbl[9].sd0 = 64'hBB; tbl[9].sd2 = 64'hAA;
        tbl[10] = v(0, 1, 0,  0, 0,  0, 0, 10, 1, 1, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[11] = v(0, 1, 1, 10, 1,  0, 0, 11, 1, 0, 0, 0, 0, RF1,        RF2,       0, 1);
        tbl[12] = v(0, 1, 0, 11, 1,  0, 0,  0, 0, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[13] = v(0, 1, 0,  0, 0,  0, 0,  0, 1, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[14] = v(0, 1, 0,  0, 1,  0, 1,  0, 0, 0, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[15] = v(0, 1, 0,  0, 0,  0, 0, 12, 1, 1, 1, 0, 0, RF1,        RF2,       0, 0);
        tbl[16] = v(1, 1, 0, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[17] = v(1, 1, 1, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       0, 0);
        tbl[18] = v(1, 1, 0, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[19] = v(1, 1, 0, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[20] = v(1, 1, 0, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[21] = v(0, 1, 0, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[22] = v(0, 1, 0, 12, 1,  0, 0, 13, 1, 0, 0, 0, 0, RF1,        RF2,       1, 0);
        tbl[23] = v(0, 1, 0, 12, 1,  0, 0, 13, 1, 0, 1, 3, 0, SD2,        RF2,       0, 0);

        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            hold = tbl[i].hold; id_valid = tbl[i].valid; redirect = tbl[i].redirect;
            rs1 = tbl[i].rs1; u1 = tbl[i].u1; rs2 = tbl[i].rs2; u2 = tbl[i].u2;
            rd = tbl[i].rd; wen = tbl[i].wen; ld = tbl[i].ld;
            stage_data = {tbl[i].sd2, tbl[i].sd1, tbl[i].sd0};
            e.idx = i; e.chk_fwd = tbl[i].chk_fwd;
            e.sel1 = tbl[i].sel1; e.sel2 = tbl[i].sel2; e.d1 = tbl[i].d1; e.d2 = tbl[i].d2;
            e.stall = tbl[i].stall; e.flush = tbl[i].flush;
            e.scnt = m_scnt; e.fcnt = m_fcnt;
            sb_q.push_back(e);
            if (!tbl[i].hold && tbl[i].stall) m_scnt++;
            if (!tbl[i].hold && tbl[i].flush) m_fcnt++;

            @(negedge clk);
            e = sb_q.pop_front();
            if (e.chk_fwd) begin
                check($sformatf("v%0d sel1", e.idx), 64'(a_sel1), 64'(e.sel1));
                check($sformatf("v%0d sel2", e.idx), 64'(a_sel2), 64'(e.sel2));
                check($sformatf("v%0d rs1", e.idx), a_rs1, e.d1);
                check($sformatf("v%0d rs2", e.idx), a_rs2, e.d2);
            end
            check($sformatf("v%0d stall", e.idx), 64'(a_stall), 64'(e.stall));
            check($sformatf("v%0d flush_if", e.idx), 64'(a_fif), 64'(e.flush));
            check($sformatf("v%0d flush_id", e.idx), 64'(a_fid), 64'(e.flush));
            check($sformatf("v%0d stall_cycles", e.idx), 64'(a_scnt), 64'(e.scnt));
            check($sformatf("v%0d flush_count", e.idx), 64'(a_fcnt), 64'(e.fcnt));
            check($sformatf("v%0d sat stall_cycles", e.idx), 64'(b_scnt),
                  64'((e.scnt > 15) ? 15 : e.scnt));
        end
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        // Three valid writers in flight, then an async reset in the middle of a cycle.
        stage_data = {SD2, SD1, SD0};
        @(posedge clk); #1; drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        @(posedge clk); #1; drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0);
        @(posedge clk); #1; drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, 1'b1);
        @(posedge clk); #1; drive_id(1'b1, 5'd22, 1'b1, 5'd21, 1'b1, 5'd23, 1'b1, 1'b0);
        #1;
        check("pre-reset load-use stall", 64'(a_stall), 64'd1);
        check("pre-reset sel2", 64'(a_sel2), 64'd2);
        check("pre-reset scnt nonzero", 64'(a_scnt != 0), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_values("async rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("post rst");

        // Ten load/use pairs produce 20 stalls; the 4-bit counter must stop at 15.
        for (int it = 0; it < 10; it++) begin
            @(posedge clk); #1; drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1; drive_id(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
                @(negedge clk);
                check($sformatf("sat it%0d c%0d stall", it, c), 64'(a_stall), 64'd1);
            end
        end
        @(posedge clk); #1; drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("wide stall_cycles after 20 stalls", 64'(a_scnt), 64'd20);
        check("4-bit stall_cycles saturated", 64'(b_scnt), 64'd15);
        check("flush_count after reset", 64'(a_fcnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
